// File: rtl/accum_seq_pkg.sv
// accum_seq_pkg: shared types and defaults for the accumulate-job sequencer.
//   state_e         : controller states (IDLE, CLEAR, FEED, FINISH)
//   STATE_W         : state encoding width
//   DATA_W_DEF      : operand / sum width default
//   CNT_W_DEF       : job length field width default
//   TIMEOUT_CYC_DEF : idle cycles tolerated between operands (timeout build)
//   cnt_bits()      : counter width able to hold 0..limit
package accum_seq_pkg;

  localparam int unsigned DATA_W_DEF      = 8;
  localparam int unsigned CNT_W_DEF       = 4;
  localparam int unsigned TIMEOUT_CYC_DEF = 255;
  localparam int unsigned STATE_W         = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE   = 2'd0,
    CLEAR  = 2'd1,
    FEED   = 2'd2,
    FINISH = 2'd3
  } state_e;

  // Width of a counter that must reach 'limit' (at least one bit).
  function automatic int unsigned cnt_bits(input int unsigned limit);
    return (limit < 2) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/accum_seq_if.sv
// accum_seq_if: operand valid/ready stream feeding the sequencer.
//   op_valid : source has an operand
//   op_data  : operand value
//   op_ready : sequencer accepts the operand this cycle
// Modports: master = operand source, slave = sequencer.
interface accum_seq_if #(
  parameter int unsigned DATA_W = 8
);

  logic              op_valid;
  logic [DATA_W-1:0] op_data;
  logic              op_ready;

  modport master (
    output op_valid,
    output op_data,
    input  op_ready
  );

  modport slave (
    input  op_valid,
    input  op_data,
    output op_ready
  );

endinterface

// File: rtl/accum_seq_timer.sv
// accum_seq_timer: loadable idle-cycle counter used to abort a stalled job.
//   clock, reset : rising-edge clock, async active-high reset
//   clr          : reload the counter to zero (entering FEED or on handshake)
//   inc          : count one idle cycle (while in FEED)
//   expired_c    : this idle cycle makes the count reach LIMIT
module accum_seq_timer
  import accum_seq_pkg::*;
#(
  parameter int unsigned LIMIT = TIMEOUT_CYC_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic expired_c
);

  localparam int unsigned W = cnt_bits(LIMIT);

  logic [W-1:0] cnt;

  // Saturating idle counter; clr has priority over inc.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != W'(LIMIT))) begin
      cnt <= cnt + W'(1);
    end
  end

  // Flag the cycle whose closing edge would bring the count to LIMIT.
  assign expired_c = inc && (cnt == W'(LIMIT - 1));

endmodule

// File: rtl/accum_sequencer.sv
// accum_sequencer: steps an external accumulator datapath through one job
// (clear, then N operand additions) and reports the final sum with sticky
// carry / signed-overflow flags and a one-cycle done pulse.
//   clock, reset   : rising-edge clock, async active-high reset
//   start, count   : job request and operand count (sampled in IDLE only)
//   op             : operand stream (accum_seq_if.slave)
//   acc_clr        : clear the datapath (one cycle, CLEAR state)
//   acc_en         : datapath adds acc_operand at this edge (handshake)
//   acc_operand    : operand to datapath (follows op_data)
//   acc_sum        : datapath registered sum
//   acc_cout/ovf   : datapath combinational carry / overflow of sum+operand
//   busy           : controller not idle
//   done           : one-cycle job-complete pulse
//   result         : final sum, held until next done
//   carry_sticky   : OR of acc_cout over the job's adds
//   ovf_sticky     : OR of acc_ovf over the job's adds
//   remaining      : operands still to accept
//   timeout        : (ACCUM_SEQ_TIMEOUT_EN only) pulses with done on abort
// Optional feature macro: ACCUM_SEQ_TIMEOUT_EN (idle timeout in FEED).
module accum_sequencer
  import accum_seq_pkg::*;
#(
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF
`ifdef ACCUM_SEQ_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
`endif
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [CNT_W-1:0]  count,
  accum_seq_if.slave        op,
  output logic              acc_clr,
  output logic              acc_en,
  output logic [DATA_W-1:0] acc_operand,
  input  logic [DATA_W-1:0] acc_sum,
  input  logic              acc_cout,
  input  logic              acc_ovf,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              carry_sticky,
  output logic              ovf_sticky,
  output logic [CNT_W-1:0]  remaining
`ifdef ACCUM_SEQ_TIMEOUT_EN
  ,
  output logic              timeout
`endif
);

  state_e state;
  logic   carry_int;
  logic   ovf_int;
  logic   hs_c;

  // op_ready is only ever high in FEED, so a handshake implies FEED.
  assign hs_c        = op.op_valid && op.op_ready;
  assign acc_en      = hs_c;
  assign acc_operand = op.op_data;

`ifdef ACCUM_SEQ_TIMEOUT_EN
  logic expired_c;

  // Idle counter restarts when FEED is entered (armed in CLEAR) and on every accepted operand.
  accum_seq_timer #(
    .LIMIT (TIMEOUT_CYC)
  ) u_timer (
    .clock     (clock),
    .reset     (reset),
    .clr       ((state == CLEAR) || hs_c),
    .inc       (state == FEED),
    .expired_c (expired_c)
  );
`endif

  // Controller: state plus all registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      op.op_ready  <= 1'b0;
      acc_clr      <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      result       <= '0;
      carry_sticky <= 1'b0;
      ovf_sticky   <= 1'b0;
      remaining    <= '0;
      carry_int    <= 1'b0;
      ovf_int      <= 1'b0;
`ifdef ACCUM_SEQ_TIMEOUT_EN
      timeout      <= 1'b0;
`endif
    end else begin
      acc_clr <= 1'b0;
      done    <= 1'b0;
`ifdef ACCUM_SEQ_TIMEOUT_EN
      timeout <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (start) begin
            remaining <= count;
            carry_int <= 1'b0;
            ovf_int   <= 1'b0;
            busy      <= 1'b1;
            acc_clr   <= 1'b1;
            state     <= CLEAR;
          end
        end

        CLEAR: begin
          if (remaining != '0) begin
            op.op_ready <= 1'b1;
            state       <= FEED;
          end else begin
            state <= FINISH;
          end
        end

        FEED: begin
          if (hs_c) begin
            remaining <= remaining - CNT_W'(1);
            carry_int <= carry_int | acc_cout;
            ovf_int   <= ovf_int | acc_ovf;
            if (remaining == CNT_W'(1)) begin
              op.op_ready <= 1'b0;
              state       <= FINISH;
            end
          end
`ifdef ACCUM_SEQ_TIMEOUT_EN
          // Stalled job: report what has been summed so far, keep remaining.
          else if (expired_c && !op.op_valid) begin
            result       <= acc_sum;
            carry_sticky <= carry_int;
            ovf_sticky   <= ovf_int;
            done         <= 1'b1;
            timeout      <= 1'b1;
            busy         <= 1'b0;
            op.op_ready  <= 1'b0;
            state        <= IDLE;
          end
`endif
        end

        FINISH: begin
          // The last add has landed in acc_sum by now.
          result       <= acc_sum;
          carry_sticky <= carry_int;
          ovf_sticky   <= ovf_int;
          done         <= 1'b1;
          busy         <= 1'b0;
          state        <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
